uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tick_div.sv | 33 +++
 rtl/uart_tx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: FSM state encoding and
// default frame geometry.
package uart_pkg;

    localparam int unsigned DBIT_DEF = 8;
    localparam int unsigned OVS_DEF  = 16;
    localparam int unsigned LIMIT_W  = 14;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tick_div.sv
// Baud tick divider: counts 0..limit and emits tick on the terminal count.
module uart_tick_div
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [LIMIT_W-1:0] limit,
    output logic               tick
);

    logic [LIMIT_W-1:0] cnt_q;
    logic [LIMIT_W-1:0] cnt_d;

    assign tick = (cnt_q == limit);

    // Clearing on acceptance aligns the first bit to a full tick period.
    always_comb begin
        cnt_d = cnt_q + LIMIT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity,
// one or two stop bits; each bit lasts OVS baud ticks.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DBIT = DBIT_DEF,
    parameter int unsigned OVS  = OVS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LIMIT_W-1:0] limit,
    input  logic [DBIT-1:0]    tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic               parity_en,
    input  logic               parity_odd,
    input  logic               two_stop,
    output logic               tx,
    output logic               busy,
    output logic               done_tick
);

    localparam int unsigned TW = $clog2(2 * OVS);
    localparam int unsigned BW = (DBIT > 1) ? $clog2(DBIT) : 1;

    state_t             state_q,    state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DBIT-1:0]    shreg_q,    shreg_d;
    logic [LIMIT_W-1:0] limit_q,    limit_d;
    logic               par_en_q,   par_en_d;
    logic               par_bit_q,  par_bit_d;
    logic               two_stop_q, two_stop_d;
    logic               tx_q,       tx_d;
    logic               busy_q,     busy_d;
    logic               ready_q,    ready_d;
    logic               done_q,     done_d;

    logic               accept;
    logic               tick;
    logic               bit_end;
    logic [TW-1:0]      stop_last;
    logic [DBIT-1:0]    shreg_next;

    assign accept     = tx_valid & ready_q;
    assign bit_end    = tick && (tick_cnt_q == TW'(OVS - 1));
    assign stop_last  = two_stop_q ? TW'(2 * OVS - 1) : TW'(OVS - 1);
    assign shreg_next = shreg_q >> 1;

    uart_tick_div u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .limit (limit_q),
        .tick  (tick)
    );

    // Next-state and next-output logic; tx is precomputed so it is registered.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        limit_d    = limit_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shreg_d    = tx_data;
                    limit_d    = limit;
                    par_en_d   = parity_en;
                    par_bit_d  = (^tx_data) ^ parity_odd;
                    two_stop_d = two_stop;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d    = ST_DATA;
                    tick_cnt_d = '0;
                    tx_d       = shreg_q[0];
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    if (bit_cnt_q == BW'(DBIT - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shreg_d   = shreg_next;
                        tx_d      = shreg_next[0];
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    tick_cnt_d = '0;
                    tx_d       = 1'b1;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick && (tick_cnt_q == stop_last)) begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    done_d     = 1'b1;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            limit_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            limit_q    <= limit_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign tx_ready  = ready_q;
    assign done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus randomized frames
// compared cycle by cycle against a bit-timeline model of the serial line.
module tb_uart_tx_ctrl;

    localparam int unsigned DBIT = 8;
    localparam int unsigned OVS  = 16;

    typedef struct {
        logic [DBIT-1:0] data;
        logic [13:0]     lim;
        logic            pen;
        logic            podd;
        logic            two;
    } cfg_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [13:0]     limit;
    logic [DBIT-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            parity_en;
    logic            parity_odd;
    logic            two_stop;
    logic            tx;
    logic            busy;
    logic            done_tick;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DBIT(DBIT), .OVS(OVS)) dut (
        .clk        (clk),
        .reset      (reset),
        .limit      (limit),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx         (tx),
        .busy       (busy),
        .done_tick  (done_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cfg_t mk_cfg(input logic [DBIT-1:0] d, input int lim,
                                    input bit pen, input bit podd, input bit two);
        cfg_t c;
        c.data = d;
        c.lim  = 14'(lim);
        c.pen  = pen;
        c.podd = podd;
        c.two  = two;
        return c;
    endfunction

    function automatic cfg_t rand_cfg(input int maxlim);
        return mk_cfg(DBIT'($urandom), int'($urandom_range(maxlim, 0)),
                      1'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    // Total serial bits times bit duration in clk cycles.
    function automatic int frame_len(input cfg_t c);
        return (2 + DBIT + int'(c.pen) + int'(c.two)) * OVS * (int'(c.lim) + 1);
    endfunction

    // Level expected on the line k cycles after the acceptance edge.
    function automatic logic exp_bit(input cfg_t c, input int k);
        int b;
        b = k / (OVS * (int'(c.lim) + 1));
        if (b == 0) return 1'b0;
        if (b <= DBIT) return c.data[b-1];
        if (c.pen && b == DBIT + 1) return (^c.data) ^ c.podd;
        return 1'b1;
    endfunction

    task automatic drive(input cfg_t c, input logic v);
        tx_data    = c.data;
        limit      = c.lim;
        parity_en  = c.pen;
        parity_odd = c.podd;
        two_stop   = c.two;
        tx_valid   = v;
    endtask

    // Called at a negedge with the DUT idle; the request is accepted at the next edge.
    task automatic run_frame(input cfg_t c, input bit chain, input cfg_t nxt,
                             input int abort_at, input string name);
        int n;
        n = frame_len(c);
        chk({name, " ready_pre"}, 32'(tx_ready), 32'd1);
        chk({name, " tx_pre"}, 32'(tx), 32'd1);
        drive(c, 1'b1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({name, " tx"}, 32'(tx), 32'(exp_bit(c, k)));
            chk({name, " busy"}, 32'(busy), 32'd1);
            chk({name, " ready"}, 32'(tx_ready), 32'd0);
            chk({name, " done"}, 32'(done_tick), 32'd0);
            if (k == abort_at) begin
                reset    = 1'b1;
                tx_valid = 1'b0;
                @(negedge clk);
                chk({name, " abort_tx"}, 32'(tx), 32'd1);
                chk({name, " abort_busy"}, 32'(busy), 32'd0);
                chk({name, " abort_ready"}, 32'(tx_ready), 32'd1);
                chk({name, " abort_done"}, 32'(done_tick), 32'd0);
                reset = 1'b0;
                repeat (3 * OVS) begin
                    @(negedge clk);
                    chk({name, " post_abort_done"}, 32'(done_tick), 32'd0);
                    chk({name, " post_abort_tx"}, 32'(tx), 32'd1);
                end
                return;
            end
            if (chain) drive(nxt, 1'b1);
            else       drive(rand_cfg(16383), 1'($urandom));
        end
        @(negedge clk);
        chk({name, " end_done"}, 32'(done_tick), 32'd1);
        chk({name, " end_ready"}, 32'(tx_ready), 32'd1);
        chk({name, " end_busy"}, 32'(busy), 32'd0);
        chk({name, " end_tx"}, 32'(tx), 32'd1);
        if (!chain) begin
            tx_valid = 1'b0;
            @(negedge clk);
            chk({name, " idle_done"}, 32'(done_tick), 32'd0);
            chk({name, " idle_ready"}, 32'(tx_ready), 32'd1);
            chk({name, " idle_tx"}, 32'(tx), 32'd1);
        end
    endtask

    initial begin
        cfg_t cur;
        cfg_t nxt;
        bit   chain;

        // Reset wins over a simultaneous request.
        reset = 1'b1;
        drive(mk_cfg(8'h99, 0, 1'b0, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_done", 32'(done_tick), 32'd0);
        @(negedge clk);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        run_frame(mk_cfg(8'h55, 0, 1'b0, 1'b0, 1'b0), 1'b0, cur, -1, "f55");
        run_frame(mk_cfg(8'h07, 2, 1'b1, 1'b0, 1'b0), 1'b0, cur, -1, "par_even");
        run_frame(mk_cfg(8'h07, 2, 1'b1, 1'b1, 1'b0), 1'b0, cur, -1, "par_odd");
        run_frame(mk_cfg(8'hFF, 1, 1'b0, 1'b0, 1'b1), 1'b0, cur, -1, "two_stop");
        run_frame(mk_cfg(8'h00, 0, 1'b0, 1'b0, 1'b0), 1'b0, cur, 49, "abort");

        // Back-to-back with the held request; limit raised during the first frame.
        nxt = mk_cfg(8'h3C, 5, 1'b0, 1'b0, 1'b0);
        run_frame(mk_cfg(8'hA5, 0, 1'b0, 1'b0, 1'b0), 1'b1, nxt, -1, "b2b_first");
        run_frame(nxt, 1'b0, cur, -1, "b2b_second");

        cur = rand_cfg(3);
        for (int i = 0; i < 12; i++) begin
            nxt   = rand_cfg(3);
            chain = (i < 11) ? 1'($urandom) : 1'b0;
            run_frame(cur, chain, nxt, -1, "rand");
            cur = chain ? nxt : rand_cfg(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
